// File: rtl/or_nway_pipe.sv
// Pipelined WIDTH-bit OR reduction with lowest-set-bit index, plus a sticky
// accumulated OR and a saturating hit counter fed by the beats leaving the pipe.
module or_nway_pipe #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     sticky_en,
  input  logic                     clear,
  output logic                     out_valid,
  output logic                     out,
  output logic [$clog2(WIDTH)-1:0] first_idx,
  output logic                     sticky,
  output logic [CNT_W-1:0]         hit_count
);

  localparam int IW = $clog2(WIDTH);

  // Each tree level keeps WIDTH node slots; slots past the live node count stay zero.
  typedef struct packed {
    logic [WIDTH-1:0]         hit;
    logic [WIDTH-1:0][IW-1:0] idx;
  } nodes_t;

  // Last tree level finished by register stage s; surplus stages hold no levels.
  function automatic int lvl_end(input int s);
    if (LATENCY >= IW) return (s < IW) ? s : IW;
    return (s * IW + LATENCY - 1) / LATENCY;
  endfunction

  function automatic nodes_t reduce_level(input nodes_t a);
    nodes_t r;
    r = '0;
    for (int j = 0; 2 * j < WIDTH; j++) begin
      if (a.hit[2*j]) begin
        r.hit[j] = 1'b1;
        r.idx[j] = a.idx[2*j];
      end else if (2 * j + 1 < WIDTH) begin
        if (a.hit[2*j+1]) begin
          r.hit[j] = 1'b1;
          r.idx[j] = a.idx[2*j+1];
        end
      end
    end
    return r;
  endfunction

  function automatic nodes_t reduce_n(input nodes_t a, input int n);
    nodes_t r;
    r = a;
    for (int l = 0; l < n; l++) r = reduce_level(r);
    return r;
  endfunction

  function automatic logic [IW:0] root(input nodes_t a, input int n);
    nodes_t r;
    r = a;
    for (int l = 0; l < n; l++) r = reduce_level(r);
    return {r.hit[0], r.idx[0]};
  endfunction

  nodes_t             leaf;
  logic [LATENCY-1:0] valid_q;
  logic [IW:0]        fin;

  always_comb begin
    leaf     = '0;
    leaf.hit = in_data;
    for (int i = 0; i < WIDTH; i++) leaf.idx[i] = IW'(i);
  end

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    localparam int LO = lvl_end(s);
    localparam int HI = lvl_end(s + 1);
    nodes_t src;

    if (s == 0) begin : g_first
      assign src = leaf;
    end else begin : g_next
      assign src = g_stage[s-1].g_mid.q;
    end

    // Data registers carry no reset; stale contents are masked by the valid chain.
    if (s < LATENCY - 1) begin : g_mid
      nodes_t q;
      always_ff @(posedge clk) q <= reduce_n(src, HI - LO);
    end else begin : g_last
      logic [IW:0] q;
      always_ff @(posedge clk) q <= root(src, HI - LO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  assign fin       = g_stage[LATENCY-1].g_last.q;
  assign out_valid = valid_q[LATENCY-1];
  assign out       = out_valid & fin[IW];
  assign first_idx = out_valid ? fin[IW-1:0] : '0;

  // A clear coinciding with an accumulated beat restarts the window with that beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky    <= 1'b0;
      hit_count <= '0;
    end else if (clear) begin
      if (out_valid && sticky_en) begin
        sticky    <= out;
        hit_count <= CNT_W'(out);
      end else begin
        sticky    <= 1'b0;
        hit_count <= '0;
      end
    end else if (out_valid && sticky_en) begin
      sticky <= sticky | out;
      if (out && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_or_nway_pipe.sv
// Directed bench for or_nway_pipe: default 8-bit/2-stage instance plus a
// 37-bit/4-stage instance for the one-hot sweep and random reduction checks.
module tb_or_nway_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       sticky_en;
  logic       clear;
  logic       out_valid;
  logic       out;
  logic [2:0] first_idx;
  logic       sticky;
  logic [3:0] hit_count;

  logic        w_in_valid;
  logic [36:0] w_in_data;
  logic        w_out_valid;
  logic        w_out;
  logic [5:0]  w_first_idx;
  logic        w_sticky;
  logic [3:0]  w_hit_count;

  int total = 0;
  int bad   = 0;

  or_nway_pipe #(.WIDTH(8), .LATENCY(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .sticky_en(sticky_en), .clear(clear), .out_valid(out_valid), .out(out),
    .first_idx(first_idx), .sticky(sticky), .hit_count(hit_count)
  );

  or_nway_pipe #(.WIDTH(37), .LATENCY(4), .CNT_W(4)) dut_wide (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_data(w_in_data),
    .sticky_en(1'b0), .clear(1'b0), .out_valid(w_out_valid), .out(w_out),
    .first_idx(w_first_idx), .sticky(w_sticky), .hit_count(w_hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({out_valid, out, first_idx, sticky, hit_count} !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %b want %b",
               {out_valid, out, first_idx, sticky, hit_count}, 10'b0);
    end
    total++;
    if ({w_out_valid, w_out, w_first_idx} !== 8'b0) begin
      bad++;
      $display("[TB] FAIL reset_wide: got %b want %b", {w_out_valid, w_out, w_first_idx}, 8'b0);
    end
  endtask

  task automatic test_zero_word;
    sticky_en = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    tick();
    total++;
    if ({out_valid, out, first_idx} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL zero_word: got %b want %b", {out_valid, out, first_idx}, 5'b10000);
    end
    tick();
    total++;
    if ({out_valid, sticky, hit_count} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL zero_word_acc: got %b want %b", {out_valid, sticky, hit_count}, 6'b0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] beats [4];
    logic [4:0] expv  [4];
    logic [4:0] want;
    beats = '{8'h40, 8'hA0, 8'h00, 8'hFF};
    expv  = '{5'b11110, 5'b11101, 5'b10000, 5'b11000};
    sticky_en = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? beats[c] : 8'h33;
      if (c >= 2) begin
        want = (c - 2 < 4) ? expv[c-2] : 5'b0;
        total++;
        if ({out_valid, out, first_idx} !== want) begin
          bad++;
          $display("[TB] FAIL back_to_back c%0d: got %b want %b", c, {out_valid, out, first_idx}, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_saturate;
    logic [4:0] want;
    sticky_en = 1'b1;
    in_data   = 8'h01;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 20);
      if (c >= 3) begin
        want = {1'b1, 4'((c - 2 > 15) ? 15 : c - 2)};
        total++;
        if ({sticky, hit_count} !== want) begin
          bad++;
          $display("[TB] FAIL saturate c%0d: got %b want %b", c, {sticky, hit_count}, want);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if ({sticky, hit_count} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL clear_idle: got %b want %b", {sticky, hit_count}, 5'b0);
    end
  endtask

  task automatic test_clear_with_beat;
    logic [7:0] b;
    logic [4:0] want;
    sticky_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? 8'h80 : 8'h00;
      for (int c = 0; c < 6; c++) begin
        in_valid = (c < 3);
        in_data  = (c < 2) ? 8'h01 : b;
        clear    = (c == 4);
        if (c == 4) begin
          want = (p == 0) ? 5'b11111 : 5'b10000;
          total++;
          if ({out_valid, out, first_idx} !== want) begin
            bad++;
            $display("[TB] FAIL clear_beat_exit p%0d: got %b want %b", p, {out_valid, out, first_idx}, want);
          end
          want = (p == 0) ? 5'b10010 : 5'b10011;
          total++;
          if ({sticky, hit_count} !== want) begin
            bad++;
            $display("[TB] FAIL clear_beat_pre p%0d: got %b want %b", p, {sticky, hit_count}, want);
          end
        end
        if (c == 5) begin
          want = (p == 0) ? 5'b10001 : 5'b00000;
          total++;
          if ({sticky, hit_count} !== want) begin
            bad++;
            $display("[TB] FAIL clear_beat_post p%0d: got %b want %b", p, {sticky, hit_count}, want);
          end
        end
        tick();
      end
    end
  endtask

  task automatic test_reset_inflight;
    sticky_en = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h02;
    tick();
    in_data = 8'h10;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out, first_idx} !== 5'b11001) begin
      bad++;
      $display("[TB] FAIL inflight_pre: got %b want %b", {out_valid, out, first_idx}, 5'b11001);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({out_valid, out, first_idx, sticky, hit_count} !== 10'b0) begin
      bad++;
      $display("[TB] FAIL inflight_reset: got %b want %b",
               {out_valid, out, first_idx, sticky, hit_count}, 10'b0);
    end
    tick();
    total++;
    if ({out_valid, out, first_idx} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL inflight_dropped: got %b want %b", {out_valid, out, first_idx}, 5'b0);
    end
  endtask

  task automatic test_idle_hold;
    sticky_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 2);
      in_data  = (c == 0) ? 8'h04 : (c == 1) ? 8'h20 : 8'($urandom);
      if (c >= 4) begin
        total++;
        if ({out_valid, sticky, hit_count} !== 6'b010010) begin
          bad++;
          $display("[TB] FAIL idle_hold c%0d: got %b want %b", c, {out_valid, sticky, hit_count}, 6'b010010);
        end
      end
      tick();
    end
    sticky_en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        in_valid = (c == 0);
        in_data  = 8'hFF;
        clear    = (p == 1 && c == 2);
        if (c == 2) begin
          total++;
          if ({out_valid, out, first_idx} !== 5'b11000) begin
            bad++;
            $display("[TB] FAIL noacc_exit p%0d: got %b want %b", p, {out_valid, out, first_idx}, 5'b11000);
          end
        end
        if (c == 3) begin
          total++;
          if ({sticky, hit_count} !== ((p == 0) ? 5'b10010 : 5'b00000)) begin
            bad++;
            $display("[TB] FAIL noacc_acc p%0d: got %b want %b", p, {sticky, hit_count},
                     (p == 0) ? 5'b10010 : 5'b00000);
          end
        end
        tick();
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_wide_sweep;
    logic [7:0] want;
    for (int c = 0; c < 42; c++) begin
      w_in_valid = (c < 37);
      w_in_data  = (c < 37) ? (37'd1 << c) : 37'h1F_FFFF_FFFF;
      if (c >= 4) begin
        want = (c - 4 < 37) ? {2'b11, 6'(c - 4)} : 8'b0;
        total++;
        if ({w_out_valid, w_out, w_first_idx} !== want) begin
          bad++;
          $display("[TB] FAIL wide_sweep c%0d: got %b want %b", c, {w_out_valid, w_out, w_first_idx}, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_wide_random;
    logic [7:0]  expq[$];
    logic [7:0]  want;
    logic [36:0] w;
    logic [5:0]  ref_idx;
    int          sel;
    for (int c = 0; c < 2004; c++) begin
      if (c < 2000) begin
        sel = $urandom_range(0, 7);
        w   = 37'({$urandom, $urandom});
        if (sel == 0) w = '0;
        else if (sel == 1) w = 37'd1 << $urandom_range(0, 36);
        else if (sel < 5) w = w & 37'({$urandom, $urandom}) & 37'({$urandom, $urandom});
        ref_idx = '0;
        for (int k = 36; k >= 0; k--) if (w[k]) ref_idx = 6'(k);
        w_in_valid = 1'b1;
        w_in_data  = w;
        expq.push_back({1'b1, |w, ref_idx});
      end else begin
        w_in_valid = 1'b0;
      end
      if (c >= 4) begin
        want = expq.pop_front();
        total++;
        if ({w_out_valid, w_out, w_first_idx} !== want) begin
          bad++;
          $display("[TB] FAIL wide_random c%0d: got %b want %b", c, {w_out_valid, w_out, w_first_idx}, want);
        end
      end
      tick();
    end
    total++;
    if (w_out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wide_random_drain: got %b want %b", w_out_valid, 1'b0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    sticky_en  = 1'b0;
    clear      = 1'b0;
    w_in_valid = 1'b0;
    w_in_data  = '0;
    #1;
    test_reset();
    test_zero_word();
    test_back_to_back();
    test_saturate();
    test_clear_with_beat();
    test_reset_inflight();
    test_idle_hold();
    test_wide_sweep();
    test_wide_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
